// File: rtl/draw_ray_line.sv
// Minimap ray renderer: Bresenham line from the player's pixel to the hit cell's pixel,
// written one pixel per cycle on the VGA port, answering the main FSM's start/done handshake.
module draw_ray_line (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic        busy,
  input  logic [13:0] x,
  input  logic [12:0] y,
  input  logic [5:0]  result_x,
  input  logic [4:0]  result_y,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_write
);

  localparam logic [2:0] COLOUR = 3'b100;

  typedef enum logic [1:0] {IDLE, SETUP, DRAW, FINISH} state_t;

  state_t             state;
  logic [6:0]         x0, x1, cx;
  logic [5:0]         y0, y1, cy;
  logic [6:0]         dx, dy_mag;
  logic               sx_pos, sy_pos;
  logic signed [9:0]  err;

  logic [6:0]         setup_dx, setup_dy;
  logic signed [10:0] e2, dx_s, dy_s;
  logic               step_x, step_y, at_end;
  logic signed [9:0]  err_next;
  logic [6:0]         cx_next;
  logic [5:0]         cy_next;

  // NOTE: every variable written here gets a default at the top, so no path can infer a latch.
  always_comb begin
    setup_dx = (x1 > x0) ? (x1 - x0) : (x0 - x1);
    setup_dy = {1'b0, ((y1 > y0) ? (y1 - y0) : (y0 - y1))};
    e2       = {err, 1'b0};
    dx_s     = {4'b0000, dx};
    dy_s     = -{4'b0000, dy_mag};
    step_x   = (e2 >= dy_s);
    step_y   = (e2 <= dx_s);
    at_end   = (cx == x1) && (cy == y1);
    err_next = err;
    cx_next  = cx;
    cy_next  = cy;
    // Both decisions use the old err; both corrections land in the same cycle.
    if (step_x) begin
      err_next = err_next - {3'b000, dy_mag};
      cx_next  = sx_pos ? (cx + 7'd1) : (cx - 7'd1);
    end
    if (step_y) begin
      err_next = err_next + {3'b000, dx};
      cy_next  = sy_pos ? (cy + 6'd1) : (cy - 6'd1);
    end
  end

  // NOTE: reset clears every register, datapath included, so an aborted line leaves no stale state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      done       <= 1'b0;
      busy       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_write  <= 1'b0;
      x0         <= '0;
      y0         <= '0;
      x1         <= '0;
      y1         <= '0;
      cx         <= '0;
      cy         <= '0;
      dx         <= '0;
      dy_mag     <= '0;
      sx_pos     <= 1'b0;
      sy_pos     <= 1'b0;
      err        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x0    <= x[13:7];
            y0    <= y[12:7];
            x1    <= {result_x, 1'b0};
            y1    <= {result_y, 1'b0};
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          dx         <= setup_dx;
          dy_mag     <= setup_dy;
          sx_pos     <= (x0 < x1);
          sy_pos     <= (y0 < y1);
          err        <= $signed({3'b000, setup_dx}) - $signed({3'b000, setup_dy});
          cx         <= x0;
          cy         <= y0;
          vga_write  <= 1'b1;
          vga_x      <= {1'b0, x0};
          vga_y      <= {1'b0, y0};
          vga_colour <= COLOUR;
          state      <= DRAW;
        end
        DRAW: begin
          if (at_end) begin
            vga_write  <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            done       <= 1'b1;
            state      <= FINISH;
          end else begin
            cx    <= cx_next;
            cy    <= cy_next;
            err   <= err_next;
            vga_x <= {1'b0, cx_next};
            vga_y <= {1'b0, cy_next};
          end
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
